// File: rtl/mk_rst_seq_if.sv
// rtl/mk_rst_seq_if.sv - software-reset request and per-channel reset outputs of the sequencer
interface mk_rst_seq_if #(
  parameter int N_CH = 4
);
  logic            sw_rst;
  logic [N_CH-1:0] rst_out;
  logic            done;
  logic [7:0]      sw_cnt;

  modport master (input sw_rst, output rst_out, output done, output sw_cnt);
  modport slave  (output sw_rst, input rst_out, input done, input sw_cnt);
endinterface

// File: rtl/mk_rst_seq.sv
// rtl/mk_rst_seq.sv - staged multi-channel reset release after a synchronised reset or software reset
// Channel 0 leaves reset after HOLD_CYC cycles, each further channel STAGE_CYC cycles later.
module mk_rst_seq #(
  parameter int HOLD_CYC  = 65535,
  parameter int N_CH      = 4,
  parameter int STAGE_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  mk_rst_seq_if.master  bus
);
  localparam int CMAX = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N_CH + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYC - 1);
  localparam logic [IW-1:0] CH_LAST    = IW'(N_CH - 1);

  typedef enum logic [1:0] {S_HOLD, S_REL, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ch_q, ch_d;
  logic [N_CH-1:0] rst_out_q, rst_out_d;
  logic            done_q, done_d;
  logic [7:0]      sw_cnt_q, sw_cnt_d;

  logic rst_sync;
  logic sw_acc;
  logic hold_end;
  logic stage_end;
  logic last_ch;

  assign rst_sync  = sync_q[1];
  assign sw_acc    = bus.sw_rst & ~rst_sync;
  assign hold_end  = (cnt_q == HOLD_LAST);
  assign stage_end = (cnt_q == STAGE_LAST);
  assign last_ch   = (ch_q == CH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      ch_q      <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      sw_cnt_q  <= 8'd0;
    end else begin
      sync_q    <= {sync_q[0], 1'b0};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      sw_cnt_q  <= sw_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sw_acc) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD:  if (!rst_sync && hold_end) state_d = (N_CH == 1) ? S_RUN : S_REL;
        S_REL:   if (stage_end && last_ch) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Software reset wins over any in-flight release once the synchroniser has let go.
  always_comb begin
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    sw_cnt_d  = sw_cnt_q;
    if (sw_acc) begin
      rst_out_d = '1;
      done_d    = 1'b0;
      cnt_d     = '0;
      ch_d      = '0;
      if (sw_cnt_q != 8'hFF) sw_cnt_d = sw_cnt_q + 8'd1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (!rst_sync) begin
            if (hold_end) begin
              rst_out_d[0] = 1'b0;
              cnt_d        = '0;
              ch_d         = IW'(1);
              done_d       = (N_CH == 1);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_REL: begin
          if (stage_end) begin
            for (int k = 0; k < N_CH; k++) begin
              if (IW'(k) == ch_q) rst_out_d[k] = 1'b0;
            end
            cnt_d = '0;
            ch_d  = ch_q + IW'(1);
            if (last_ch) done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
    bus.rst_out = rst_out_q;
    bus.done    = done_q;
    bus.sw_cnt  = sw_cnt_q;
  end
endmodule

// File: tb/tb_mk_rst_seq.sv
// tb/tb_mk_rst_seq.sv - randomized reset/sw_rst stimulus against an elapsed-edge reference model
// Two instances: (HOLD=4,N=3,STAGE=2) and (HOLD=1,N=1,STAGE=1) share clk, rst and sw_rst.
module tb_mk_rst_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw  = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model: e = edges since E0 (-1 before E0), m = edges since accepted sw_rst (-1 if none).
  int e   = -1;
  int m   = -1;
  int swc = 0;

  int rst_hold = 0;
  int sw_hold  = 0;

  mk_rst_seq_if #(.N_CH(3)) bus_a ();
  mk_rst_seq_if #(.N_CH(1)) bus_b ();

  assign bus_a.sw_rst = sw;
  assign bus_b.sw_rst = sw;

  mk_rst_seq #(.HOLD_CYC(4), .N_CH(3), .STAGE_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mk_rst_seq #(.HOLD_CYC(1), .N_CH(1), .STAGE_CYC(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = -1; m = -1; swc = 0;
    end else begin
      if (e < 0) e = 0;
      else if (e < 1000000) e++;
      if (m >= 0 && m < 1000000) m++;
      if (sw && e >= 2) begin
        m = 0;
        if (swc < 255) swc++;
      end
    end
  end

  function automatic bit released(int h, int s, int k);
    if (m >= 0) return m >= h + k * s;
    return (e >= 0) && (e >= h + 1 + k * s);
  endfunction

  function automatic int exp_out(int h, int n, int s);
    int v = 0;
    for (int k = 0; k < n; k++) if (!released(h, s, k)) v |= (1 << k);
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("rst_out_a", int'(bus_a.rst_out), exp_out(4, 3, 2));
    chk("done_a",    int'(bus_a.done),    int'(released(4, 2, 2)));
    chk("sw_cnt_a",  int'(bus_a.sw_cnt),  swc);
    chk("rst_out_b", int'(bus_b.rst_out), exp_out(1, 1, 1));
    chk("done_b",    int'(bus_b.done),    int'(released(1, 1, 0)));
    chk("sw_cnt_b",  int'(bus_b.sw_cnt),  swc);
  endtask

  task automatic async_check();
    chk("async_rst_out_a", int'(bus_a.rst_out), 7);
    chk("async_done_a",    int'(bus_a.done),    0);
    chk("async_sw_cnt_a",  int'(bus_a.sw_cnt),  0);
    chk("async_rst_out_b", int'(bus_b.rst_out), 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 async_check();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) step();

    // one-cycle software reset in RUN
    sw = 1'b1;
    step();
    sw = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // software reset mid-release, then async reset mid-release
    sw = 1'b1;
    step();
    sw = 1'b0;
    for (int i = 0; i < 6; i++) step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b1;
    #1 async_check();
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // long hold: sw_cnt must saturate
    sw = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("sw_cnt_saturated", int'(bus_a.sw_cnt), 255);
    sw = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // sw_rst while synchroniser still holds reset is ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    sw  = 1'b1;
    step();
    step();
    sw = 1'b0;
    chk("sw_ignored_in_sync", int'(bus_a.sw_cnt), 0);
    for (int i = 0; i < 12; i++) step();

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      step();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 199) < 3) begin
        #($urandom_range(1, 2)) rst = 1'b1;
        #1 async_check();
        if ($urandom_range(0, 1) == 1) #1 rst = 1'b0;
        else rst_hold = $urandom_range(1, 4);
      end
      if (sw_hold > 0) begin
        sw_hold--;
        sw = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        sw_hold = $urandom_range(2, 20);
        sw = 1'b1;
      end else begin
        sw = ($urandom_range(0, 19) == 0);
      end
    end
    rst = 1'b0;
    sw  = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mk_rst_seq.md
MK_RST_SEQ -- requirements
Module: mk_rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 65535: hold cycles after synchronised reset release before channel 0 is released; legal range >=1.
REQ-002 SHALL have parameter N_CH, default 4: number of reset channels; legal range >=1.
REQ-003 SHALL have parameter STAGE_CYC, default 16: cycles between successive channel releases; legal range >=1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port sw_rst, input, 1 bit: synchronous software-reset request, active-high, sampled every edge.
REQ-007 SHALL have port rst_out, output, N_CH bits: per-channel active-high reset, registered.
REQ-008 SHALL have port done, output, 1 bit: all channels released.
REQ-009 SHALL have port sw_cnt, output, 8 bits: saturating count of accepted software resets.

Function
REQ-010 SHALL derive internal counter widths from HOLD_CYC, STAGE_CYC and N_CH with $clog2; no overflow for any legal value.
REQ-011 SHALL pass rst deassertion through a 2-flop synchroniser (flops set to 1 by rst, shifting in 0); rst_sync is the second flop.
REQ-012 SHALL implement FSM states HOLD, REL, RUN.
REQ-013 HOLD: while rst_sync=0, cnt increments each edge from 0; at edge with cnt==HOLD_CYC-1: rst_out[0]<=0, cnt<=0, ch_idx<=1, state<=REL; if N_CH==1, state<=RUN and done<=1 instead.
REQ-014 REL: cnt increments each edge; at edge with cnt==STAGE_CYC-1: rst_out[ch_idx]<=0, cnt<=0, ch_idx<=ch_idx+1; if ch_idx==N_CH-1, state<=RUN and done<=1.
REQ-015 RUN: outputs hold (rst_out all 0, done=1) until sw_rst or rst.
REQ-016 Channel k SHALL be released exactly HOLD_CYC+1+k*STAGE_CYC edges after the first edge at which rst is sampled low (edge E0); done rises on the same edge as channel N_CH-1.
REQ-017 Released channels SHALL never reassert except on rst or accepted sw_rst; a channel SHALL never release before a lower-indexed channel.
REQ-018 sw_rst=1 with rst_sync=0, in any state: at that edge, all rst_out<=1, done<=0, cnt<=0, ch_idx<=0, state<=HOLD, sw_cnt<=sw_cnt+1 saturating at 255.
REQ-019 sw_rst held high SHALL re-accept every edge: counter stays 0, sw_cnt increments per edge (saturating), no release until sw_rst low.
REQ-020 sw_rst while rst_sync=1 SHALL be ignored (sw_cnt unchanged).
REQ-021 After sw_rst, release timing SHALL follow REQ-013/014: channel k released at edge S+HOLD_CYC+k*STAGE_CYC, where S is the accepting edge (no synchroniser delay).

Reset
REQ-022 rst=1 SHALL immediately and asynchronously force rst_out all 1, done=0, sw_cnt=0, cnt=0, ch_idx=0, state=HOLD, synchroniser flops=1, including mid-REL and mid-RUN.
REQ-023 rst pulses of any length, including sub-cycle, SHALL restart the full sequence from E0 of the following deassertion.

Verification (HOLD_CYC=4, N_CH=3, STAGE_CYC=2 unless noted)
REQ-024 Power-up: rst high, then low before E0 -> rst_out=111 through E4; 110 after E5; 100 after E7; 000 and done=1 after E9.
REQ-025 sw_rst one-cycle pulse at edge S in RUN -> rst_out=111, done=0, sw_cnt=1 after S; 110 after S+4; 100 after S+6; 000 after S+8.
REQ-026 sw_rst pulse mid-REL (rst_out=110) -> immediate 111, full sequence restarts per REQ-025; rst asserted mid-REL -> asynchronous 111, sw_cnt=0.
REQ-027 sw_rst held 300 cycles -> sw_cnt saturates at 255, rst_out=111 throughout, sequence resumes after release; sw_rst during rst_sync=1 -> sw_cnt stays 0.
REQ-028 N_CH=1, HOLD_CYC=1 -> rst_out[0] and done change 1->0 / 0->1 at E2; defaults (65535/4/16) -> channel 3 released at E65584.
